// File: rtl/reg_file.sv
// Architectural register file with per-register rename state (busy bit + producer ROB tag).
// Issue reads combinationally with a commit bypass; commit retires values, flush drops renames.
module reg_file #(
  parameter int ROB_SIZE_LOG = 4,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    commit_enable,
  input  logic [4:0]              commit_regid,
  input  logic [XLEN-1:0]         commit_value,
  input  logic [ROB_SIZE_LOG-1:0] commit_robid,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [ROB_SIZE_LOG-1:0] issue_robid,
  input  logic [4:0]              rs1_query,
  input  logic [4:0]              rs2_query,
  output logic                    rs1_busy,
  output logic [ROB_SIZE_LOG-1:0] rs1_robid,
  output logic [XLEN-1:0]         rs1_value,
  output logic                    rs2_busy,
  output logic [ROB_SIZE_LOG-1:0] rs2_robid,
  output logic [XLEN-1:0]         rs2_value
);

  localparam int NREG = 32;

  typedef struct packed {
    logic                    busy;
    logic [ROB_SIZE_LOG-1:0] robid;
    logic [XLEN-1:0]         value;
  } read_t;

  logic [XLEN-1:0]         regs [NREG];
  logic [ROB_SIZE_LOG-1:0] tag  [NREG];
  logic [NREG-1:0]         busy;

  logic  commit_write;
  logic  issue_write;
  read_t rs1_read;
  read_t rs2_read;

  assign commit_write = commit_enable && (commit_regid != 5'd0);
  assign issue_write  = issue_valid && (issue_rd != 5'd0) && !flush;

  // Issue is applied after commit so a same-register rename in the same cycle wins the busy bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (commit_write) begin
        regs[commit_regid] <= commit_value;
        if (tag[commit_regid] == commit_robid)
          busy[commit_regid] <= 1'b0;
      end
      if (flush)
        busy <= '0;
      else if (issue_write) begin
        busy[issue_rd] <= 1'b1;
        tag[issue_rd]  <= issue_robid;
      end
    end
  end

  // A retiring producer is forwarded in the same cycle; flush and rdy do not gate this.
  function automatic read_t lookup(input logic [4:0] q);
    read_t r;
    r.busy  = 1'b0;
    r.robid = tag[q];
    r.value = regs[q];
    if (q == 5'd0) begin
      r.robid = '0;
      r.value = '0;
    end else if (commit_enable && (commit_regid == q) && busy[q] &&
                 (tag[q] == commit_robid)) begin
      r.value = commit_value;
    end else begin
      r.busy = busy[q];
    end
    return r;
  endfunction

  always_comb begin
    rs1_read = lookup(rs1_query);
    rs2_read = lookup(rs2_query);
  end

  assign rs1_busy  = rs1_read.busy;
  assign rs1_robid = rs1_read.robid;
  assign rs1_value = rs1_read.value;
  assign rs2_busy  = rs2_read.busy;
  assign rs2_robid = rs2_read.robid;
  assign rs2_value = rs2_read.value;

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file: each vector drives one cycle of inputs,
// checks both combinational read ports before the clock edge, then lets the edge apply.
module tb_reg_file;

  localparam int RL = 4;
  localparam int XL = 32;
  localparam int NVEC = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          flush;
  logic          commit_enable;
  logic [4:0]    commit_regid;
  logic [XL-1:0] commit_value;
  logic [RL-1:0] commit_robid;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [RL-1:0] issue_robid;
  logic [4:0]    rs1_query;
  logic [4:0]    rs2_query;
  logic          rs1_busy;
  logic [RL-1:0] rs1_robid;
  logic [XL-1:0] rs1_value;
  logic          rs2_busy;
  logic [RL-1:0] rs2_robid;
  logic [XL-1:0] rs2_value;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic          rdy;
    logic          flush;
    logic          ce;
    logic [4:0]    cid;
    logic [XL-1:0] cval;
    logic [RL-1:0] crob;
    logic          iv;
    logic [4:0]    ird;
    logic [RL-1:0] irob;
    logic [4:0]    q1;
    logic [4:0]    q2;
    logic          b1;
    logic [RL-1:0] t1;
    logic [XL-1:0] v1;
    logic          b2;
    logic [RL-1:0] t2;
    logic [XL-1:0] v2;
  } vec_t;

  vec_t vecs [NVEC];

  reg_file #(.ROB_SIZE_LOG(RL), .XLEN(XL)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .flush(flush),
    .commit_enable(commit_enable),
    .commit_regid(commit_regid),
    .commit_value(commit_value),
    .commit_robid(commit_robid),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_robid(issue_robid),
    .rs1_query(rs1_query),
    .rs2_query(rs2_query),
    .rs1_busy(rs1_busy),
    .rs1_robid(rs1_robid),
    .rs1_value(rs1_value),
    .rs2_busy(rs2_busy),
    .rs2_robid(rs2_robid),
    .rs2_value(rs2_value)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    rdy           = v.rdy;
    flush         = v.flush;
    commit_enable = v.ce;
    commit_regid  = v.cid;
    commit_value  = v.cval;
    commit_robid  = v.crob;
    issue_valid   = v.iv;
    issue_rd      = v.ird;
    issue_robid   = v.irob;
    rs1_query     = v.q1;
    rs2_query     = v.q2;
  endtask

  task automatic checkOutput(input string name, input int port,
                             input logic eb, input logic [RL-1:0] et, input logic [XL-1:0] ev);
    logic          ab;
    logic [RL-1:0] at;
    logic [XL-1:0] av;
    ab = (port == 1) ? rs1_busy  : rs2_busy;
    at = (port == 1) ? rs1_robid : rs2_robid;
    av = (port == 1) ? rs1_value : rs2_value;
    checks++;
    if (ab === eb && at === et && av === ev)
      passes++;
    else
      $display("[TB] FAIL %s rs%0d: got busy=%b robid=%0d value=%h, expected busy=%b robid=%0d value=%h",
               name, port, ab, at, av, eb, et, ev);
  endtask

  initial begin
    //          rdy fl ce cid cval         crob iv ird irob q1  q2  b1 t1  v1           b2 t2  v2
    vecs[0]  = '{1, 0, 1, 0,  32'hDEAD,    0,   0, 0,  0,   5,  0,  0, 0,  0,           0, 0,  0};
    vecs[1]  = '{1, 0, 0, 0,  0,           0,   1, 3,  2,   3,  0,  0, 0,  0,           0, 0,  0};
    vecs[2]  = '{1, 0, 0, 0,  0,           0,   0, 0,  0,   3,  0,  1, 2,  0,           0, 0,  0};
    vecs[3]  = '{1, 0, 1, 3,  32'h11,      2,   0, 0,  0,   3,  3,  0, 2,  32'h11,      0, 2,  32'h11};
    vecs[4]  = '{1, 0, 0, 0,  0,           0,   1, 4,  1,   3,  4,  0, 2,  32'h11,      0, 0,  0};
    vecs[5]  = '{1, 0, 0, 0,  0,           0,   1, 4,  5,   4,  3,  1, 1,  0,           0, 2,  32'h11};
    vecs[6]  = '{1, 0, 1, 4,  7,           1,   0, 0,  0,   4,  4,  1, 5,  0,           1, 5,  0};
    vecs[7]  = '{1, 0, 0, 0,  0,           0,   1, 6,  3,   4,  6,  1, 5,  7,           0, 0,  0};
    vecs[8]  = '{1, 0, 1, 6,  9,           3,   1, 6,  7,   6,  0,  0, 3,  9,           0, 0,  0};
    vecs[9]  = '{1, 0, 0, 0,  0,           0,   1, 1,  8,   6,  4,  1, 7,  9,           1, 5,  7};
    vecs[10] = '{1, 0, 0, 0,  0,           0,   1, 2,  9,   1,  2,  1, 8,  0,           0, 0,  0};
    vecs[11] = '{1, 0, 0, 0,  0,           0,   1, 3,  10,  2,  3,  1, 9,  0,           0, 2,  32'h11};
    vecs[12] = '{1, 1, 1, 2,  32'h42,      4,   1, 9,  11,  2,  9,  1, 9,  0,           0, 0,  0};
    vecs[13] = '{1, 0, 0, 0,  0,           0,   0, 0,  0,   1,  3,  0, 8,  0,           0, 10, 32'h11};
    vecs[14] = '{1, 0, 0, 0,  0,           0,   0, 0,  0,   2,  9,  0, 9,  32'h42,      0, 0,  0};
    vecs[15] = '{1, 0, 0, 0,  0,           0,   0, 0,  0,   6,  4,  0, 7,  9,           0, 5,  7};
    vecs[16] = '{0, 0, 1, 7,  32'h77,      0,   1, 5,  12,  5,  7,  0, 0,  0,           0, 0,  0};
    vecs[17] = '{1, 0, 1, 7,  32'h77,      0,   1, 5,  12,  5,  7,  0, 0,  0,           0, 0,  0};
    vecs[18] = '{1, 0, 0, 0,  0,           0,   0, 0,  0,   5,  7,  1, 12, 0,           0, 0,  32'h77};
    vecs[19] = '{0, 0, 1, 5,  32'h55,      12,  0, 0,  0,   5,  5,  0, 12, 32'h55,      0, 12, 32'h55};
    vecs[20] = '{1, 0, 0, 0,  0,           0,   1, 31, 15,  5,  31, 1, 12, 0,           0, 0,  0};
    vecs[21] = '{1, 0, 0, 0,  0,           0,   0, 0,  0,   31, 0,  1, 15, 0,           0, 0,  0};

    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    commit_enable = 1'b0;
    commit_regid = '0;
    commit_value = '0;
    commit_robid = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_robid = '0;
    rs1_query = 5'd5;
    rs2_query = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), 1, vecs[i].b1, vecs[i].t1, vecs[i].v1);
      checkOutput($sformatf("vec%0d", i), 2, vecs[i].b2, vecs[i].t2, vecs[i].v2);
    end

    // Reset must win over rdy=0 and over a pending issue/commit in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b0;
    flush = 1'b0;
    commit_enable = 1'b1;
    commit_regid = 5'd6;
    commit_value = 32'hFF;
    commit_robid = 4'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    issue_robid = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b1;
    commit_enable = 1'b0;
    issue_valid = 1'b0;
    rs1_query = 5'd5;
    rs2_query = 5'd31;
    #1;
    checkOutput("reset_x5", 1, 1'b0, 4'd0, 32'h0);
    checkOutput("reset_x31", 2, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    rs1_query = 5'd6;
    rs2_query = 5'd3;
    #1;
    checkOutput("reset_x6", 1, 1'b0, 4'd0, 32'h0);
    checkOutput("reset_x3", 2, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    rs1_query = 5'd7;
    rs2_query = 5'd2;
    #1;
    checkOutput("reset_x7", 1, 1'b0, 4'd0, 32'h0);
    checkOutput("reset_x2", 2, 1'b0, 4'd0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
